core_req_master: RTL and testbench
==================================

# core_req_master

Bus initiator for the core memory port: accepts one load/store command at a time from the pipeline over a valid/ready handshake and drives the `req_*` side of the core bus. It holds the request until `ack_val`, then returns aligned and extended read data, or an error on misalignment/timeout, as a one-cycle response. It sits between the CPU load/store path and the memory/bus responder, and is the RTL counterpart of the bus's acknowledging side.

## Interface
- `TIMEOUT`, 256, cycles `req_val` stays high without `ack_val` before the request is abandoned (≥2)
- `clk`  in  1  clock, all logic on posedge
- `rst`  in  1  reset; synchronous, active-high
- `cmd_val`  in  1  pipeline command valid
- `cmd_rdy`  out  1  command accepted when `cmd_val & cmd_rdy`
- `cmd_we`  in  1  1=store, 0=load
- `cmd_addr`  in  32  byte address
- `cmd_size`  in  3  0=byte, 1=half, 2=word; others illegal (treated as misaligned)
- `cmd_unsigned`  in  1  load zero-extends when 1, sign-extends when 0
- `cmd_wdata`  in  32  store data, right-justified
- `rsp_val`  out  1  one-cycle response pulse; no backpressure
- `rsp_rdata`  out  32  extended load data; 0 for stores and errors
- `rsp_err`  out  1  valid with `rsp_val`: misaligned or timed out
- `stray_ack`  out  1  one-cycle pulse when `ack_val` arrives outside REQ
- `req_val`  out  1  bus request valid
- `req_addr`  out  32  word-aligned address (`cmd_addr & ~3`)
- `req_cop`  out  3  0=read, 1=write
- `req_wdata`  out  32  lane-replicated store data
- `req_size`  out  3  `cmd_size` as latched
- `req_be`  out  4  byte enables
- `ack_val`  in  1  responder acknowledge
- `ack_rdata`  in  32  read data, valid with `ack_val`

## Operation
- FSM states: IDLE, REQ, RSP.
- IDLE: `cmd_rdy`=1. On accept, latch the command.
  - If aligned, go to REQ.
  - If misaligned (half with `addr[0]`≠0, word with `addr[1:0]`≠0, or size>2), go to RSP with err=1 and issue no bus request.
- REQ: `req_val`=1; all `req_*` stay stable for the whole state.
  - On `ack_val`, capture `ack_rdata` and go to RSP with err=0.
  - If the wait counter reaches TIMEOUT-1 with no ack, go to RSP with err=1. An ack in that same cycle wins.
- RSP: `rsp_val`=1 for exactly one cycle, then IDLE. `cmd_rdy`=0 in REQ and RSP.
- Byte enables:
  - byte: `4'b0001<<addr[1:0]`
  - half: `4'b0011<<addr[1:0]`
  - word: `4'b1111`
  - reads drive the same BE.
- Store data replication: byte `{4{wdata[7:0]}}`, half `{2{wdata[15:0]}}`, word unchanged.
- Load extraction: `ack_rdata>>(8*addr[1:0])`, truncated to the size, then sign- or zero-extended.
- `stray_ack` pulses for any `ack_val` sampled in IDLE or RSP. The ack is otherwise ignored.

## Timing
- Reset values: state IDLE, `req_val`=0, `rsp_val`=0, `rsp_err`=0, `rsp_rdata`=0, `stray_ack`=0, `req_*` payload=0, counter=0. `cmd_rdy`=1 from the first cycle after reset.
- Bus outputs are registered. Accept at cycle N gives `req_val` high at N+1.
- Earliest legal `ack_val` is N+1 (same cycle `req_val` first rises). Ack sampled at cycle M gives `rsp_val` at M+1 and `req_val` low at M+1.
- Minimum command-to-response latency is 2 cycles. Misaligned: accept N, `rsp_val` at N+1.
- Throughput: one outstanding request. The next accept is possible in the cycle after `rsp_val`, so there are 3 cycles per command minimum.
- Timeout: `req_val` is high for exactly TIMEOUT cycles, then `rsp_val`/`rsp_err` follow.
- Counter: width `$clog2(TIMEOUT)`; cleared on REQ entry; never wraps.
- Reset mid-REQ: `req_val` drops the next cycle, no response is produced, and a late ack is reported as `stray_ack`.

## Structure
- Package `core_bus_pkg`:
  - `cop_e` (COP_RD=0, COP_WR=1)
  - `size_e` (SZ_B=0, SZ_H=1, SZ_W=2)
  - `state_e`
  - `function` for BE generation
- Sub-module `core_lane_align` (combinational):
  - misalignment check
  - BE and wdata replication
  - rdata shift/extend
- FSM, latch, and counter stay in the top module.

## Test plan
- Word load addr 0x100, ack after 3 wait cycles with rdata 0xDEADBEEF -> `req_be`=4'hF, `req_cop`=0, `req_val` high 4 cycles, `rsp_rdata`=0xDEADBEEF, `rsp_err`=0.
- Signed byte load addr 0x103, ack rdata 0x80123456 -> `req_addr`=0x100, `req_be`=4'b1000, `rsp_rdata`=0xFFFFFF80. Same with `cmd_unsigned`=1 -> 0x00000080.
- Half store addr 0x202, wdata 0x0000ABCD, ack same cycle as `req_val` rises -> `req_be`=4'b1100, `req_wdata`=0xABCDABCD, `req_cop`=1, `rsp_val` 2 cycles after accept.
- Misaligned word load addr 0x301 -> `req_val` never rises, `rsp_val`=1 with `rsp_err`=1 one cycle after accept.
- TIMEOUT=4, no ack -> `req_val` high exactly 4 cycles, then `rsp_err`=1. Rerun with ack in the 4th cycle -> `rsp_err`=0.
- Assert `rst` during REQ, then send ack 2 cycles later -> `req_val` low, no `rsp_val`, `stray_ack` pulses once, next command is accepted normally.

Source files
------------

// File: rtl/core_bus_pkg.sv
// Shared types and helpers for the core memory port initiator.
package core_bus_pkg;

    typedef enum logic [2:0] {
        COP_RD = 3'd0,
        COP_WR = 3'd1
    } cop_e;

    typedef enum logic [2:0] {
        SZ_B = 3'd0,
        SZ_H = 3'd1,
        SZ_W = 3'd2
    } size_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_RSP  = 2'd2
    } state_e;

    // Byte enables for an access of the given size at byte offset off.
    // Illegal sizes produce no enables; such commands never reach the bus.
    function automatic logic [3:0] be_gen(input logic [2:0] size, input logic [1:0] off);
        logic [3:0] be;
        case (size)
            SZ_B:    be = 4'b0001 << off;
            SZ_H:    be = 4'b0011 << off;
            SZ_W:    be = 4'b1111;
            default: be = 4'b0000;
        endcase
        return be;
    endfunction

endpackage

// File: rtl/core_lane_align.sv
// Lane steering for the core bus: alignment check, byte enables,
// store-data replication and load-data shift/extension. Purely combinational.
module core_lane_align
    import core_bus_pkg::*;
(
    input  logic [2:0]  size,
    input  logic [1:0]  off,
    input  logic        is_unsigned,
    input  logic [31:0] wdata,
    input  logic [31:0] rdata,
    output logic        misaligned,
    output logic [3:0]  be,
    output logic [31:0] wdata_rep,
    output logic [31:0] rdata_ext
);

    logic [31:0] rshift;

    assign rshift = rdata >> {off, 3'b000};

    // Per-size legality, lane replication and load extension
    always_comb begin
        misaligned = 1'b0;
        be         = be_gen(size, off);
        wdata_rep  = wdata;
        rdata_ext  = rshift;
        case (size)
            SZ_B: begin
                wdata_rep = {4{wdata[7:0]}};
                rdata_ext = is_unsigned ? {24'h0, rshift[7:0]}
                                        : {{24{rshift[7]}}, rshift[7:0]};
            end
            SZ_H: begin
                misaligned = off[0];
                wdata_rep  = {2{wdata[15:0]}};
                rdata_ext  = is_unsigned ? {16'h0, rshift[15:0]}
                                         : {{16{rshift[15]}}, rshift[15:0]};
            end
            SZ_W: begin
                misaligned = (off != 2'b00);
            end
            default: begin
                misaligned = 1'b1;
            end
        endcase
    end

endmodule

// File: rtl/core_req_master.sv
// Core memory port initiator: one outstanding load/store, registered bus
// request held until ack or timeout, one-cycle response pulse.
// Handshakes: a command transfers on the cycle where cmd_val & cmd_rdy are
// both high; the bus request is held stable while req_val is high and
// completes on the cycle ack_val is sampled; rsp_val has no backpressure.
module core_req_master
    import core_bus_pkg::*;
#(
    parameter int TIMEOUT = 256
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        cmd_val,
    output logic        cmd_rdy,
    input  logic        cmd_we,
    input  logic [31:0] cmd_addr,
    input  logic [2:0]  cmd_size,
    input  logic        cmd_unsigned,
    input  logic [31:0] cmd_wdata,
    output logic        rsp_val,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err,
    output logic        stray_ack,
    output logic        req_val,
    output logic [31:0] req_addr,
    output logic [2:0]  req_cop,
    output logic [31:0] req_wdata,
    output logic [2:0]  req_size,
    output logic [3:0]  req_be,
    input  logic        ack_val,
    input  logic [31:0] ack_rdata,
    output state_e      dbg_state
);

    localparam int CW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

    state_e        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          req_val_q, req_val_d;
    logic [31:0]   req_addr_q, req_addr_d;
    cop_e          req_cop_q, req_cop_d;
    logic [31:0]   req_wdata_q, req_wdata_d;
    logic [2:0]    req_size_q, req_size_d;
    logic [3:0]    req_be_q, req_be_d;
    logic [1:0]    off_q, off_d;
    logic          uns_q, uns_d;
    logic          rsp_val_q, rsp_val_d;
    logic          rsp_err_q, rsp_err_d;
    logic [31:0]   rsp_rdata_q, rsp_rdata_d;
    logic          stray_q, stray_d;

    logic          idle;
    logic [2:0]    al_size;
    logic [1:0]    al_off;
    logic          al_uns;
    logic          al_mis;
    logic [3:0]    al_be;
    logic [31:0]   al_wdata;
    logic [31:0]   al_rdata;

    // In IDLE the aligner looks at the incoming command; afterwards it
    // looks at the latched command so the ack data is extended correctly.
    assign idle    = (state_q == ST_IDLE);
    assign al_size = idle ? cmd_size : req_size_q;
    assign al_off  = idle ? cmd_addr[1:0] : off_q;
    assign al_uns  = idle ? cmd_unsigned : uns_q;

    core_lane_align u_align (
        .size        (al_size),
        .off         (al_off),
        .is_unsigned (al_uns),
        .wdata       (cmd_wdata),
        .rdata       (ack_rdata),
        .misaligned  (al_mis),
        .be          (al_be),
        .wdata_rep   (al_wdata),
        .rdata_ext   (al_rdata)
    );

    // State register
    always_ff @(posedge clk) begin
        if (rst) state_q <= ST_IDLE;
        else     state_q <= state_d;
    end

    // Next state: misaligned commands skip the bus; an ack beats the timeout
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (cmd_val) state_d = al_mis ? ST_RSP : ST_REQ;
            ST_REQ:  if (ack_val || (cnt_q == CNT_LAST)) state_d = ST_RSP;
            ST_RSP:  state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // Outputs and datapath: latch on accept, count in REQ, build the response
    always_comb begin
        req_addr_d  = req_addr_q;
        req_cop_d   = req_cop_q;
        req_wdata_d = req_wdata_q;
        req_size_d  = req_size_q;
        req_be_d    = req_be_q;
        off_d       = off_q;
        uns_d       = uns_q;
        cnt_d       = cnt_q;
        rsp_err_d   = 1'b0;
        rsp_rdata_d = 32'h0;
        stray_d     = ack_val && (state_q != ST_REQ);
        req_val_d   = (state_d == ST_REQ);
        rsp_val_d   = (state_d == ST_RSP);
        case (state_q)
            ST_IDLE: begin
                if (cmd_val) begin
                    req_addr_d  = {cmd_addr[31:2], 2'b00};
                    req_cop_d   = cmd_we ? COP_WR : COP_RD;
                    req_wdata_d = al_wdata;
                    req_size_d  = cmd_size;
                    req_be_d    = al_be;
                    off_d       = cmd_addr[1:0];
                    uns_d       = cmd_unsigned;
                    cnt_d       = '0;
                    rsp_err_d   = al_mis;
                end
            end
            ST_REQ: begin
                if (ack_val) begin
                    rsp_rdata_d = (req_cop_q == COP_RD) ? al_rdata : 32'h0;
                end else if (cnt_q == CNT_LAST) begin
                    rsp_err_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: ;
        endcase
    end

    // Registered bus and response outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q       <= '0;
            req_val_q   <= 1'b0;
            req_addr_q  <= 32'h0;
            req_cop_q   <= COP_RD;
            req_wdata_q <= 32'h0;
            req_size_q  <= 3'h0;
            req_be_q    <= 4'h0;
            off_q       <= 2'h0;
            uns_q       <= 1'b0;
            rsp_val_q   <= 1'b0;
            rsp_err_q   <= 1'b0;
            rsp_rdata_q <= 32'h0;
            stray_q     <= 1'b0;
        end else begin
            cnt_q       <= cnt_d;
            req_val_q   <= req_val_d;
            req_addr_q  <= req_addr_d;
            req_cop_q   <= req_cop_d;
            req_wdata_q <= req_wdata_d;
            req_size_q  <= req_size_d;
            req_be_q    <= req_be_d;
            off_q       <= off_d;
            uns_q       <= uns_d;
            rsp_val_q   <= rsp_val_d;
            rsp_err_q   <= rsp_err_d;
            rsp_rdata_q <= rsp_rdata_d;
            stray_q     <= stray_d;
        end
    end

    assign cmd_rdy   = idle;
    assign req_val   = req_val_q;
    assign req_addr  = req_addr_q;
    assign req_cop   = req_cop_q;
    assign req_wdata = req_wdata_q;
    assign req_size  = req_size_q;
    assign req_be    = req_be_q;
    assign rsp_val   = rsp_val_q;
    assign rsp_err   = rsp_err_q;
    assign rsp_rdata = rsp_rdata_q;
    assign stray_ack = stray_q;
    assign dbg_state = state_q;

endmodule

// File: tb/tb_core_req_master.sv
// Bench for core_req_master: directed cases plus random commands, checked by
// a scoreboard against a byte-level reference model.
module tb_core_req_master;
  import core_bus_pkg::*;

  localparam int TO = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        cmd_val, cmd_rdy, cmd_we, cmd_unsigned;
  logic [31:0] cmd_addr, cmd_wdata;
  logic [2:0]  cmd_size;
  logic        rsp_val, rsp_err, stray_ack, req_val, ack_val;
  logic [31:0] rsp_rdata, req_addr, req_wdata, ack_rdata;
  logic [2:0]  req_cop, req_size;
  logic [3:0]  req_be;
  state_e      dbg_state;

  core_req_master #(.TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst),
    .cmd_val(cmd_val), .cmd_rdy(cmd_rdy), .cmd_we(cmd_we), .cmd_addr(cmd_addr),
    .cmd_size(cmd_size), .cmd_unsigned(cmd_unsigned), .cmd_wdata(cmd_wdata),
    .rsp_val(rsp_val), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err), .stray_ack(stray_ack),
    .req_val(req_val), .req_addr(req_addr), .req_cop(req_cop), .req_wdata(req_wdata),
    .req_size(req_size), .req_be(req_be), .ack_val(ack_val), .ack_rdata(ack_rdata),
    .dbg_state(dbg_state)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, got timeout want completion");
    $fatal(1, "watchdog");
  end

  // ---------------- scoreboard state ----------------
  typedef struct {
    logic [31:0] addr;
    logic [2:0]  cop;
    logic [31:0] wdata;
    logic [2:0]  size;
    logic [3:0]  be;
    bit          we;
    int          dur;
  } req_t;

  typedef struct {
    logic        err;
    logic [31:0] rdata;
    int          cyc;
  } rsp_t;

  req_t exp_req_q[$];
  rsp_t exp_q[$];
  int   total = 0;
  int   bad = 0;
  int   stray_seen = 0;
  int   exp_stray = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic flag(input string name);
    total++;
    bad++;
    $display("FAIL %s: got event want none (cycle %0d)", name, cyc);
  endtask

  // ---------------- reference model ----------------
  // Byte-count arithmetic: alignment by modulo, enables as a run of ones,
  // store lanes by repetition, loads by shifting, masking and two's complement.
  function automatic void model(input logic [31:0] addr, input logic [2:0] size,
                                input logic uns, input logic [31:0] wd, input logic [31:0] rd,
                                output bit mis, output logic [3:0] be,
                                output logic [31:0] wrep, output logic [31:0] rext);
    int nb;
    int off;
    longint v;
    longint lim;
    off = int'(addr % 4);
    nb = (size == 3'd0) ? 1 : (size == 3'd1) ? 2 : 4;
    mis = (size > 3'd2) || ((addr % nb) != 0);
    be = 4'(((1 << nb) - 1) << off);
    for (int i = 0; i < 4; i++) wrep[8*i +: 8] = wd[8*(i % nb) +: 8];
    v = longint'({32'h0, rd}) >> (8 * off);
    lim = 64'sd1 <<< (8 * nb);
    v = v % lim;
    if (!uns && v >= lim / 2) v = v - lim;
    rext = v[31:0];
  endfunction

  // ---------------- monitor ----------------
  req_t cur_req;
  bit   req_active = 0;
  bit   have_req = 0;
  int   req_cnt = 0;
  bit   prev_rsp = 0;

  task automatic check_req(input req_t r);
    chk("req_addr", req_addr, r.addr);
    chk("req_cop", 32'(req_cop), 32'(r.cop));
    chk("req_size", 32'(req_size), 32'(r.size));
    chk("req_be", 32'(req_be), 32'(r.be));
    if (r.we) chk("req_wdata", req_wdata, r.wdata);
  endtask

  always @(negedge clk) begin
    if (req_val === 1'b1) begin
      if (!req_active) begin
        req_active = 1;
        req_cnt = 1;
        have_req = (exp_req_q.size() != 0);
        if (have_req) cur_req = exp_req_q.pop_front();
        else flag("req_unexpected");
      end else begin
        req_cnt++;
      end
      if (have_req) check_req(cur_req);
    end else if (req_active) begin
      req_active = 0;
      if (have_req) chk("req_high_cycles", 32'(req_cnt), 32'(cur_req.dur));
    end

    if (rsp_val === 1'b1) begin
      rsp_t e;
      if (prev_rsp) flag("rsp_two_cycles");
      else if (exp_q.size() == 0) flag("rsp_unexpected");
      else begin
        e = exp_q.pop_front();
        chk("rsp_err", 32'(rsp_err), 32'(e.err));
        chk("rsp_rdata", rsp_rdata, e.rdata);
        chk("rsp_cycle", 32'(cyc), 32'(e.cyc));
      end
    end
    prev_rsp = (rsp_val === 1'b1);

    if (stray_ack === 1'b1) stray_seen++;
  end

  // ---------------- driver tasks ----------------
  // Called at posedge+1. d = wait cycles before ack; d >= TO means no ack.
  task automatic do_cmd(input logic we, input logic [31:0] addr, input logic [2:0] size,
                        input logic uns, input logic [31:0] wd, input int d,
                        input logic [31:0] rd);
    bit mis;
    bit tmo;
    logic [3:0] be;
    logic [31:0] wrep, rext;
    req_t er;
    rsp_t es;
    int n;
    model(addr, size, uns, wd, rd, mis, be, wrep, rext);
    tmo = !mis && (d >= TO);
    cmd_val = 1'b1; cmd_we = we; cmd_addr = addr; cmd_size = size;
    cmd_unsigned = uns; cmd_wdata = wd;
    n = 0;
    @(negedge clk);
    while (cmd_rdy !== 1'b1 && n < 50) begin @(negedge clk); n++; end
    if (cmd_rdy !== 1'b1) begin
      flag("cmd_accept_timeout");
      @(posedge clk); #1;
      cmd_val = 1'b0;
      return;
    end
    er.addr = addr & 32'hFFFF_FFFC;
    er.cop = we ? 3'd1 : 3'd0;
    er.wdata = wrep;
    er.size = size;
    er.be = be;
    er.we = we;
    er.dur = tmo ? TO : d + 1;
    if (!mis) exp_req_q.push_back(er);
    es.err = mis || tmo;
    es.rdata = (es.err || we) ? 32'h0 : rext;
    es.cyc = cyc + (mis ? 1 : tmo ? TO + 1 : d + 2);
    exp_q.push_back(es);
    @(posedge clk); #1;
    cmd_val = 1'b0;
    cmd_addr = $urandom; cmd_wdata = $urandom; cmd_size = 3'($urandom);
    cmd_we = 1'($urandom); cmd_unsigned = 1'($urandom);
    if (!mis && !tmo) begin
      repeat (d) begin @(posedge clk); #1; end
      ack_val = 1'b1; ack_rdata = rd;
      @(posedge clk); #1;
      ack_val = 1'b0; ack_rdata = $urandom;
    end
    n = 0;
    while (exp_q.size() != 0 && n < TO + 10) begin @(posedge clk); #1; n++; end
    if (exp_q.size() != 0) begin
      flag("rsp_missing");
      exp_q.delete();
      exp_req_q.delete();
    end
  endtask

  task automatic stray_pulse();
    ack_val = 1'b1; ack_rdata = $urandom;
    exp_stray++;
    @(posedge clk); #1;
    ack_val = 1'b0;
  endtask

  task automatic reset_mid_req();
    req_t er;
    int s0;
    int n;
    cmd_val = 1'b1; cmd_we = 1'b0; cmd_addr = 32'h0000_0400; cmd_size = 3'd2;
    cmd_unsigned = 1'b0; cmd_wdata = 32'h0;
    n = 0;
    @(negedge clk);
    while (cmd_rdy !== 1'b1 && n < 50) begin @(negedge clk); n++; end
    er.addr = 32'h0000_0400; er.cop = 3'd0; er.wdata = 32'h0; er.size = 3'd2;
    er.be = 4'hF; er.we = 1'b0; er.dur = 2;
    exp_req_q.push_back(er);
    @(posedge clk); #1;
    cmd_val = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("rst_mid_req_val", 32'(req_val), 32'h0);
    chk("rst_mid_cmd_rdy", 32'(cmd_rdy), 32'h1);
    @(posedge clk); #1;
    s0 = stray_seen;
    ack_val = 1'b1; ack_rdata = 32'h1234_5678;
    exp_stray++;
    @(posedge clk); #1;
    ack_val = 1'b0;
    repeat (3) begin @(posedge clk); #1; end
    chk("rst_late_ack_stray", 32'(stray_seen - s0), 32'h1);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    rst = 1'b1; cmd_val = 1'b0; cmd_we = 1'b0; cmd_addr = 32'h0; cmd_size = 3'd0;
    cmd_unsigned = 1'b0; cmd_wdata = 32'h0; ack_val = 1'b0; ack_rdata = 32'h0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("rst_cmd_rdy", 32'(cmd_rdy), 32'h1);
    chk("rst_req_val", 32'(req_val), 32'h0);
    chk("rst_rsp_val", 32'(rsp_val), 32'h0);
    chk("rst_rsp_err", 32'(rsp_err), 32'h0);
    chk("rst_rsp_rdata", rsp_rdata, 32'h0);
    chk("rst_stray", 32'(stray_ack), 32'h0);
    chk("rst_req_addr", req_addr, 32'h0);
    chk("rst_req_wdata", req_wdata, 32'h0);
    chk("rst_req_misc", {21'h0, req_cop, req_size, req_be, 1'b0}, 32'h0);
    chk("rst_state", 32'(dbg_state), 32'(ST_IDLE));
    @(posedge clk); #1;

    // directed cases
    do_cmd(1'b0, 32'h0000_0100, 3'd2, 1'b0, 32'h0, 3, 32'hDEAD_BEEF);
    do_cmd(1'b0, 32'h0000_0103, 3'd0, 1'b0, 32'h0, 1, 32'h8012_3456);
    do_cmd(1'b0, 32'h0000_0103, 3'd0, 1'b1, 32'h0, 1, 32'h8012_3456);
    do_cmd(1'b1, 32'h0000_0202, 3'd1, 1'b0, 32'h0000_ABCD, 0, 32'hFFFF_FFFF);
    do_cmd(1'b0, 32'h0000_0301, 3'd2, 1'b0, 32'h0, 0, 32'h0);
    do_cmd(1'b0, 32'h0000_0500, 3'd2, 1'b0, 32'h0, TO, 32'h0);
    do_cmd(1'b0, 32'h0000_0502, 3'd1, 1'b0, 32'h0, TO - 1, 32'h8001_7FFF);
    do_cmd(1'b1, 32'h0000_0600, 3'd5, 1'b0, 32'h1111_2222, 0, 32'h0);
    stray_pulse();
    reset_mid_req();
    do_cmd(1'b0, 32'h0000_0700, 3'd1, 1'b1, 32'h0, 2, 32'hC0DE_F00D);

    // randomized commands
    for (int k = 0; k < 120; k++) begin
      logic [2:0] sz;
      sz = ($urandom_range(0, 9) == 0) ? 3'($urandom_range(3, 7)) : 3'($urandom_range(0, 2));
      do_cmd(1'($urandom), $urandom, sz, 1'($urandom), $urandom,
             $urandom_range(0, TO + 1), $urandom);
      if ($urandom_range(0, 4) == 0) stray_pulse();
    end

    repeat (3) begin @(posedge clk); #1; end
    chk("stray_total", 32'(stray_seen), 32'(exp_stray));
    chk("req_queue_empty", 32'(exp_req_q.size()), 32'h0);
    chk("rsp_queue_empty", 32'(exp_q.size()), 32'h0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
